// File: rtl/sync_vg_shadow.sv
// sync_vg_shadow: parametrised video timing generator with a shadowed,
// frame-boundary-applied configuration set behind a valid/ready port.
// Optional feature macro: SYNC_VG_SHADOW_INTERLACE_EN (interlaced formats).
module sync_vg_shadow #(
    parameter int unsigned X_BITS = 12,
    parameter int unsigned Y_BITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [X_BITS-1:0] cfg_h_total,
    input  logic [X_BITS-1:0] cfg_h_fp,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_bp,
    input  logic [Y_BITS-1:0] cfg_v_total_0,
    input  logic [Y_BITS-1:0] cfg_v_fp_0,
    input  logic [Y_BITS-1:0] cfg_v_sync_0,
    input  logic [Y_BITS-1:0] cfg_v_bp_0,
    input  logic [Y_BITS-1:0] cfg_v_total_1,
    input  logic [Y_BITS-1:0] cfg_v_fp_1,
    input  logic [Y_BITS-1:0] cfg_v_sync_1,
    input  logic [Y_BITS-1:0] cfg_v_bp_1,
    input  logic [X_BITS-1:0] cfg_hv_offset_0,
    input  logic [X_BITS-1:0] cfg_hv_offset_1,
    input  logic              cfg_hs_pol,
    input  logic              cfg_vs_pol,
    input  logic              cfg_interlaced,
    output logic              cfg_applied,
    output logic              cfg_err,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic              field_out,
    output logic              frame_start,
    output logic              line_start,
    output logic [X_BITS-1:0] h_count_out,
    output logic [Y_BITS:0]   v_count_out,
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS:0]   y_out
);

    // One extra bit keeps porch sums from wrapping in the DE window compares.
    localparam int unsigned XW = X_BITS + 1;
    localparam int unsigned YW = Y_BITS + 1;

    typedef struct packed {
        logic [X_BITS-1:0] h_total, h_fp, h_sync, h_bp;
        logic [Y_BITS-1:0] v_total_0, v_fp_0, v_sync_0, v_bp_0;
        logic [X_BITS-1:0] hv_offset_0;
        logic              hs_pol, vs_pol;
`ifdef SYNC_VG_SHADOW_INTERLACE_EN
        logic [Y_BITS-1:0] v_total_1, v_fp_1, v_sync_1, v_bp_1;
        logic [X_BITS-1:0] hv_offset_1;
        logic              interlaced;
`endif
    } timing_t;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

    timing_t           cfg_in, act, shadow;
    state_t            state, state_d;
    logic              cfg_bad, accept, apply;
    logic [X_BITS-1:0] h_count, cur_hv_offset, x_c;
    logic [Y_BITS-1:0] v_count, cur_v_total, cur_v_fp, cur_v_sync, cur_v_bp, y_line;
    logic              field, il, vs_hold, vs_act, hs_act, de_c;
    logic              h_last, v_last, frame_end;
    logic [XW-1:0]     h_lo;
    logic [YW-1:0]     v_lo, v_count_full, y_c;

    // Pack the configuration inputs and flag sets with a degenerate total.
    always_comb begin
        cfg_in             = '0;
        cfg_in.h_total     = cfg_h_total;
        cfg_in.h_fp        = cfg_h_fp;
        cfg_in.h_sync      = cfg_h_sync;
        cfg_in.h_bp        = cfg_h_bp;
        cfg_in.v_total_0   = cfg_v_total_0;
        cfg_in.v_fp_0      = cfg_v_fp_0;
        cfg_in.v_sync_0    = cfg_v_sync_0;
        cfg_in.v_bp_0      = cfg_v_bp_0;
        cfg_in.hv_offset_0 = cfg_hv_offset_0;
        cfg_in.hs_pol      = cfg_hs_pol;
        cfg_in.vs_pol      = cfg_vs_pol;
        cfg_bad = (cfg_h_total < X_BITS'(2)) || (cfg_v_total_0 < Y_BITS'(2));
`ifdef SYNC_VG_SHADOW_INTERLACE_EN
        cfg_in.v_total_1   = cfg_v_total_1;
        cfg_in.v_fp_1      = cfg_v_fp_1;
        cfg_in.v_sync_1    = cfg_v_sync_1;
        cfg_in.v_bp_1      = cfg_v_bp_1;
        cfg_in.hv_offset_1 = cfg_hv_offset_1;
        cfg_in.interlaced  = cfg_interlaced;
        if (cfg_interlaced && (cfg_v_total_1 < Y_BITS'(2))) begin
            cfg_bad = 1'b1;
        end
`endif
    end

`ifndef SYNC_VG_SHADOW_INTERLACE_EN
    logic unused_field1;
    assign unused_field1 = ^{cfg_v_total_1, cfg_v_fp_1, cfg_v_sync_1, cfg_v_bp_1,
                             cfg_hv_offset_1, cfg_interlaced};
`endif

    // Select the vertical set of the current field; field 0 ends in v_fp_1.
    always_comb begin
        il            = 1'b0;
        cur_v_total   = act.v_total_0;
        cur_v_fp      = act.v_fp_0;
        cur_v_sync    = act.v_sync_0;
        cur_v_bp      = act.v_bp_0;
        cur_hv_offset = act.hv_offset_0;
`ifdef SYNC_VG_SHADOW_INTERLACE_EN
        il = act.interlaced;
        if (il) begin
            if (field) begin
                cur_v_total   = act.v_total_1;
                cur_v_sync    = act.v_sync_1;
                cur_v_bp      = act.v_bp_1;
                cur_hv_offset = act.hv_offset_1;
            end else begin
                cur_v_fp = act.v_fp_1;
            end
        end
`endif
    end

    assign h_last    = (h_count == act.h_total - X_BITS'(1));
    assign v_last    = (v_count == cur_v_total - Y_BITS'(1));
    assign frame_end = h_last && v_last && (!il || field);
    assign accept    = cfg_valid && cfg_ready;

    // Shadow handshake state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Shadow handshake next state: idle -> pending -> applied -> idle.
    always_comb begin
        state_d = state;
        apply   = 1'b0;
        case (state)
            S_IDLE: if (accept && !cfg_bad) state_d = S_PEND;
            S_PEND: if (frame_end) begin
                state_d = S_DONE;
                apply   = 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Active/shadow sets and handshake outputs; reset reloads from the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            act         <= cfg_in;
            shadow      <= '0;
            cfg_ready   <= 1'b0;
            cfg_applied <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (apply) act <= shadow;
            if (accept && !cfg_bad) shadow <= cfg_in;
            cfg_ready   <= (state_d == S_IDLE);
            cfg_applied <= apply;
            cfg_err     <= accept && cfg_bad;
        end
    end

    // Raster counters and field; applying a new set always restarts in field 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            field   <= 1'b0;
        end else if (h_last) begin
            h_count <= '0;
            if (v_last) begin
                v_count <= '0;
                if (apply)   field <= 1'b0;
                else if (il) field <= ~field;
                else         field <= 1'b0;
            end else begin
                v_count <= v_count + Y_BITS'(1);
            end
        end else begin
            h_count <= h_count + X_BITS'(1);
        end
    end

    // Sync, DE window and active coordinates from the current counters.
    always_comb begin
        hs_act = (h_count < act.h_sync);
        if ((v_count == '0) && (h_count == cur_hv_offset))              vs_act = 1'b1;
        else if ((v_count == cur_v_sync) && (h_count == cur_hv_offset)) vs_act = 1'b0;
        else                                                            vs_act = vs_hold;
        h_lo = XW'(act.h_sync) + XW'(act.h_bp);
        v_lo = YW'(cur_v_sync) + YW'(cur_v_bp);
        de_c = (XW'(h_count) >= h_lo)
            && (XW'(h_count) + XW'(act.h_fp) < XW'(act.h_total))
            && (YW'(v_count) >= v_lo)
            && (YW'(v_count) + YW'(cur_v_fp) < YW'(cur_v_total));
        x_c    = h_count - X_BITS'(h_lo);
        y_line = v_count - Y_BITS'(v_lo);
        y_c    = il ? {y_line, field} : {1'b0, y_line};
        v_count_full = field ? (YW'(v_count) + YW'(act.v_total_0)) : YW'(v_count);
    end

    // Registered timing outputs, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_hold     <= 1'b0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            de_out      <= 1'b0;
            field_out   <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            h_count_out <= '0;
            v_count_out <= '0;
            x_out       <= '0;
            y_out       <= '0;
        end else begin
            vs_hold     <= vs_act;
            hs_out      <= hs_act ~^ act.hs_pol;
            vs_out      <= vs_act ~^ act.vs_pol;
            de_out      <= de_c;
            field_out   <= field;
            frame_start <= (h_count == '0) && (v_count == '0) && !field;
            line_start  <= (h_count == '0);
            h_count_out <= h_count;
            v_count_out <= v_count_full;
            x_out       <= de_c ? x_c : '0;
            y_out       <= de_c ? y_c : '0;
        end
    end

endmodule

// File: tb/tb_sync_vg_shadow.sv
// Self-checking bench for sync_vg_shadow: table of raster points plus
// hand-written handshake, reject and reset-with-pending sequences.
module tb_sync_vg_shadow;

    localparam int unsigned XB = 12;
    localparam int unsigned YB = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [XB-1:0] cfg_h_total, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [YB-1:0] cfg_v_total_0, cfg_v_fp_0, cfg_v_sync_0, cfg_v_bp_0;
    logic [YB-1:0] cfg_v_total_1, cfg_v_fp_1, cfg_v_sync_1, cfg_v_bp_1;
    logic [XB-1:0] cfg_hv_offset_0, cfg_hv_offset_1;
    logic          cfg_hs_pol, cfg_vs_pol, cfg_interlaced;
    logic          cfg_applied, cfg_err;
    logic          hs_out, vs_out, de_out, field_out, frame_start, line_start;
    logic [XB-1:0] h_count_out, x_out;
    logic [YB:0]   v_count_out, y_out;

    int checks = 0;
    int errors = 0;
    int n = 0;

    typedef struct {
        int off;
        bit hs; bit vs; bit de;
        int x;  int y;
        bit fs; bit ls;
        int hc; int vc;
    } vec_t;

    vec_t tbl [0:13];

    sync_vg_shadow #(.X_BITS(XB), .Y_BITS(YB)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_total(cfg_h_total), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_total_0(cfg_v_total_0), .cfg_v_fp_0(cfg_v_fp_0), .cfg_v_sync_0(cfg_v_sync_0), .cfg_v_bp_0(cfg_v_bp_0),
        .cfg_v_total_1(cfg_v_total_1), .cfg_v_fp_1(cfg_v_fp_1), .cfg_v_sync_1(cfg_v_sync_1), .cfg_v_bp_1(cfg_v_bp_1),
        .cfg_hv_offset_0(cfg_hv_offset_0), .cfg_hv_offset_1(cfg_hv_offset_1),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_interlaced(cfg_interlaced),
        .cfg_applied(cfg_applied), .cfg_err(cfg_err),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .field_out(field_out),
        .frame_start(frame_start), .line_start(line_start),
        .h_count_out(h_count_out), .v_count_out(v_count_out), .x_out(x_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic set_base(input int ht, input bit pol);
        cfg_valid = 1'b0;
        cfg_h_total = XB'(ht); cfg_h_fp = 2; cfg_h_sync = 2; cfg_h_bp = 2;
        cfg_v_total_0 = 6; cfg_v_fp_0 = 1; cfg_v_sync_0 = 1; cfg_v_bp_0 = 1;
        cfg_v_total_1 = 6; cfg_v_fp_1 = 1; cfg_v_sync_1 = 1; cfg_v_bp_1 = 1;
        cfg_hv_offset_0 = 0; cfg_hv_offset_1 = 0;
        cfg_hs_pol = pol; cfg_vs_pol = pol; cfg_interlaced = 1'b0;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_hs"}, 32'(hs_out), 0);
        chk({tag, "_vs"}, 32'(vs_out), 0);
        chk({tag, "_de"}, 32'(de_out), 0);
        chk({tag, "_field"}, 32'(field_out), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_ls"}, 32'(line_start), 0);
        chk({tag, "_applied"}, 32'(cfg_applied), 0);
        chk({tag, "_err"}, 32'(cfg_err), 0);
        chk({tag, "_ready"}, 32'(cfg_ready), 0);
        chk({tag, "_x"}, 32'(x_out), 0);
        chk({tag, "_y"}, 32'(y_out), 0);
        chk({tag, "_hc"}, 32'(h_count_out), 0);
        chk({tag, "_vc"}, 32'(v_count_out), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step(); step();
        check_reset_zero("reset");
        reset = 1'b0;
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        while (frame_start !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        if (frame_start !== 1'b1) chk("wait_frame_start", 0, 1);
        n = 0;
    endtask

    task automatic run_table(input bit inv);
        int hs_n, vs_n, de_n, fs_n, ls_n;
        wait_fs();
        for (int i = 0; i < 14; i++) begin
            while (n < tbl[i].off) step();
            chk($sformatf("hs@%0d", tbl[i].off), 32'(hs_out), 32'(tbl[i].hs ^ inv));
            chk($sformatf("vs@%0d", tbl[i].off), 32'(vs_out), 32'(tbl[i].vs ^ inv));
            chk($sformatf("de@%0d", tbl[i].off), 32'(de_out), 32'(tbl[i].de));
            chk($sformatf("x@%0d", tbl[i].off), 32'(x_out), 32'(tbl[i].x));
            chk($sformatf("y@%0d", tbl[i].off), 32'(y_out), 32'(tbl[i].y));
            chk($sformatf("fs@%0d", tbl[i].off), 32'(frame_start), 32'(tbl[i].fs));
            chk($sformatf("ls@%0d", tbl[i].off), 32'(line_start), 32'(tbl[i].ls));
            chk($sformatf("hc@%0d", tbl[i].off), 32'(h_count_out), 32'(tbl[i].hc));
            chk($sformatf("vc@%0d", tbl[i].off), 32'(v_count_out), 32'(tbl[i].vc));
        end
        hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0; ls_n = 0;
        for (int k = 0; k < 60; k++) begin
            if (hs_out !== inv) hs_n++;
            if (vs_out !== inv) vs_n++;
            if (de_out === 1'b1) de_n++;
            if (frame_start === 1'b1) fs_n++;
            if (line_start === 1'b1) ls_n++;
            step();
        end
        chk("frame_hs_active", 32'(hs_n), 12);
        chk("frame_vs_active", 32'(vs_n), 10);
        chk("frame_de", 32'(de_n), 12);
        chk("frame_fs", 32'(fs_n), 1);
        chk("frame_ls", 32'(ls_n), 6);
    endtask

    initial begin
        int k, rdy_n, app_n;
        //                off hs vs de x  y  fs ls hc vc
        tbl[0]  = '{ 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        tbl[1]  = '{ 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{ 2, 0, 1, 0, 0, 0, 0, 0, 2, 0};
        tbl[3]  = '{ 9, 0, 1, 0, 0, 0, 0, 0, 9, 0};
        tbl[4]  = '{10, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{23, 0, 0, 0, 0, 0, 0, 0, 3, 2};
        tbl[6]  = '{24, 0, 0, 1, 0, 0, 0, 0, 4, 2};
        tbl[7]  = '{27, 0, 0, 1, 3, 0, 0, 0, 7, 2};
        tbl[8]  = '{28, 0, 0, 0, 0, 0, 0, 0, 8, 2};
        tbl[9]  = '{35, 0, 0, 1, 1, 1, 0, 0, 5, 3};
        tbl[10] = '{47, 0, 0, 1, 3, 2, 0, 0, 7, 4};
        tbl[11] = '{54, 0, 0, 0, 0, 0, 0, 0, 4, 5};
        tbl[12] = '{59, 0, 0, 0, 0, 0, 0, 0, 9, 5};
        tbl[13] = '{60, 1, 1, 0, 0, 0, 1, 1, 0, 0};

        // Progressive, active-high syncs.
        set_base(10, 1'b1);
        do_reset();
        run_table(1'b0);

        // Same set, active-low syncs.
        set_base(10, 1'b0);
        do_reset();
        run_table(1'b1);

        // Mid-frame update to h_total=12 applies at the frame boundary.
        set_base(10, 1'b1);
        do_reset();
        wait_fs();
        while (n < 25) step();
        chk("ready_idle", 32'(cfg_ready), 1);
        cfg_h_total = 12;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("ready_after_accept", 32'(cfg_ready), 0);
        chk("err_on_valid_set", 32'(cfg_err), 0);
        rdy_n = 0;
        k = 0;
        while (cfg_applied !== 1'b1 && k < 200) begin
            if (cfg_ready !== 1'b0) rdy_n++;
            step();
            k++;
        end
        chk("applied_cycle", 32'(n), 59);
        chk("old_h_at_end", 32'(h_count_out), 9);
        chk("old_v_at_end", 32'(v_count_out), 5);
        chk("ready_at_apply", 32'(cfg_ready), 0);
        chk("ready_while_pending", 32'(rdy_n), 0);
        step();
        chk("new_frame_start", 32'(frame_start), 1);
        chk("applied_one_pulse", 32'(cfg_applied), 0);
        chk("ready_after_apply", 32'(cfg_ready), 1);
        app_n = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (cfg_applied === 1'b1) app_n++;
        end
        chk("new_line_h11", 32'(h_count_out), 11);
        chk("new_line_v0", 32'(v_count_out), 0);
        step();
        if (cfg_applied === 1'b1) app_n++;
        chk("new_line_wrap_hc", 32'(h_count_out), 0);
        chk("new_line_wrap_ls", 32'(line_start), 1);
        chk("new_line_wrap_vc", 32'(v_count_out), 1);
        chk("applied_extra_pulses", 32'(app_n), 0);

        // Rejected set: h_total=1.
        cfg_h_total = 1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_h_total = 12;
        chk("reject_err_pulse", 32'(cfg_err), 1);
        chk("reject_ready", 32'(cfg_ready), 1);
        step();
        chk("reject_err_clear", 32'(cfg_err), 0);
        k = 0;
        while (line_start !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        app_n = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (cfg_applied === 1'b1) app_n++;
        end
        chk("reject_keeps_h11", 32'(h_count_out), 11);
        step();
        chk("reject_keeps_ls", 32'(line_start), 1);
        chk("reject_no_apply", 32'(app_n), 0);
        chk("reject_ready_after", 32'(cfg_ready), 1);

        // Reset with a pending update discards it; new inputs take effect.
        set_base(10, 1'b1);
        do_reset();
        wait_fs();
        while (n < 10) step();
        cfg_h_total = 12;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("pending_before_reset", 32'(cfg_ready), 0);
        cfg_h_total = 8;
        reset = 1'b1;
        step();
        check_reset_zero("midreset");
        step();
        reset = 1'b0;
        step();
        chk("post_reset_fs", 32'(frame_start), 1);
        chk("post_reset_ready", 32'(cfg_ready), 1);
        app_n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cfg_applied === 1'b1) app_n++;
        end
        chk("post_reset_line_hc", 32'(h_count_out), 0);
        chk("post_reset_line_ls", 32'(line_start), 1);
        chk("post_reset_line_vc", 32'(v_count_out), 1);
        for (int i = 0; i < 100; i++) begin
            step();
            if (cfg_applied === 1'b1) app_n++;
        end
        chk("post_reset_no_apply", 32'(app_n), 0);

`ifdef SYNC_VG_SHADOW_INTERLACE_EN
        begin
            int vmax, tog, lsb_bad, fs_n;
            logic prev;
            set_base(10, 1'b1);
            cfg_interlaced = 1'b1;
            cfg_v_total_0 = 5;
            cfg_v_total_1 = 6;
            do_reset();
            wait_fs();
            vmax = 0; tog = 0; lsb_bad = 0; fs_n = 0;
            prev = field_out;
            for (int i = 0; i < 220; i++) begin
                if (int'(v_count_out) > vmax) vmax = int'(v_count_out);
                if (field_out !== prev) tog++;
                prev = field_out;
                if (de_out === 1'b1 && y_out[0] !== field_out) lsb_bad++;
                if (frame_start === 1'b1) fs_n++;
                step();
            end
            chk("il_vcount_max", 32'(vmax), 10);
            chk("il_field_toggles", 32'(tog), 3);
            chk("il_y_lsb_field", 32'(lsb_bad), 0);
            chk("il_frame_starts", 32'(fs_n), 2);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
